// File: rtl/frame_bit_serializer.sv
// Byte-to-bit frame serializer: preamble, FRAME_BYTES payload bytes, then CRC-8 when the
// CRC_EN macro is defined. Bits leave MSB first, one per consumer acknowledge.
module frame_bit_serializer #(
    parameter int unsigned FRAME_BYTES = 16,
    parameter int unsigned PRE_LEN     = 16,
    parameter logic [31:0] PREAMBLE    = 32'h0000F0A5
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_byte,
    input  logic       i_byte_valid,
    output logic       o_byte_ready,
    input  logic       i_start,
    output logic       o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_busy,
    output logic       o_underrun
);
    localparam int unsigned PRE_W  = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;
    localparam int unsigned BYTE_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int unsigned BIT_W  = 3;

`ifdef CRC_EN
    localparam logic [7:0] CRC_POLY = 8'h07;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PRE = 2'd1, S_PAY = 2'd2, S_CRC = 2'd3} state_e;
    logic [7:0] crc_q, crc_d;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PRE = 2'd1, S_PAY = 2'd2} state_e;
`endif

    state_e              state_q, state_d;
    logic [7:0]          hr_q, hr_d, sr_q, sr_d;
    logic                hr_full_q, hr_full_d, sr_full_q, sr_full_d;
    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                ready_q, ready_d, data_q, data_d, valid_q, valid_d;
    logic                busy_q, busy_d, underrun_q, underrun_d;
    logic [4:0]          pre_idx;

    logic ack, accept, last_pre, last_bit, last_byte, pay_ack, byte_done, frame_end;
    logic sr_want, hr_to_sr;

    assign ack       = i_ready && valid_q;
    assign accept    = i_byte_valid && ready_q;
    assign last_pre  = (pre_cnt_q == PRE_W'(PRE_LEN - 1));
    assign last_bit  = (bit_cnt_q == BIT_W'(7));
    assign last_byte = (byte_cnt_q == BYTE_W'(FRAME_BYTES - 1));
    assign pay_ack   = (state_q == S_PAY) && ack;
    assign byte_done = pay_ack && last_bit;
    assign frame_end = byte_done && last_byte;
    // SR pulls a byte while the frame still needs payload; never past the frame's last byte
    assign sr_want   = ((state_q == S_PRE) || (state_q == S_PAY)) &&
                       (!sr_full_q || (byte_done && !last_byte));
    assign hr_to_sr  = sr_want && hr_full_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (i_start && hr_full_q) state_d = S_PRE;
            S_PRE:  if (ack && last_pre)      state_d = S_PAY;
`ifdef CRC_EN
            S_PAY:  if (frame_end)            state_d = S_CRC;
            S_CRC:  if (ack && last_bit)      state_d = S_IDLE;
`else
            S_PAY:  if (frame_end)            state_d = S_IDLE;
`endif
            default:                          state_d = S_IDLE;
        endcase
    end

    // Datapath next values; registered outputs are derived from the next state
    always_comb begin
        hr_d       = accept ? i_byte : hr_q;
        hr_full_d  = accept || (hr_full_q && !hr_to_sr);
        sr_d       = sr_q;
        sr_full_d  = sr_full_q;
        pre_cnt_d  = pre_cnt_q;
        byte_cnt_d = byte_cnt_q;
        bit_cnt_d  = bit_cnt_q;

        if (hr_to_sr) begin
            sr_d      = hr_q;
            sr_full_d = 1'b1;
        end else if (byte_done) begin
            sr_full_d = 1'b0;
        end else if (pay_ack) begin
            sr_d = {sr_q[6:0], 1'b0};
        end

        if ((state_q == S_PRE) && ack) pre_cnt_d = last_pre ? '0 : pre_cnt_q + PRE_W'(1);
        if (ack && (state_q != S_PRE)) bit_cnt_d = bit_cnt_q + BIT_W'(1);
        if (byte_done) byte_cnt_d = last_byte ? '0 : byte_cnt_q + BYTE_W'(1);

`ifdef CRC_EN
        crc_d = crc_q;
        if ((state_q == S_IDLE) && (state_d == S_PRE)) crc_d = 8'h00;
        else if (pay_ack) crc_d = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ data_q) ? CRC_POLY : 8'h00);
        else if ((state_q == S_CRC) && ack) crc_d = {crc_q[6:0], 1'b0};
`endif

        pre_idx = 5'(PRE_LEN - 1) - 5'(pre_cnt_d);
        case (state_d)
            S_PRE:   data_d = PREAMBLE[pre_idx];
            S_PAY:   data_d = sr_full_d && sr_d[7];
`ifdef CRC_EN
            S_CRC:   data_d = crc_d[7];
`endif
            default: data_d = 1'b0;
        endcase

        valid_d    = (state_d != S_IDLE) && !((state_d == S_PAY) && !sr_full_d);
        busy_d     = (state_d != S_IDLE);
        ready_d    = !hr_full_d;
        underrun_d = byte_done && !last_byte && !hr_full_q;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            hr_q       <= '0;
            hr_full_q  <= 1'b0;
            sr_q       <= '0;
            sr_full_q  <= 1'b0;
            pre_cnt_q  <= '0;
            byte_cnt_q <= '0;
            bit_cnt_q  <= '0;
            ready_q    <= 1'b0;
            data_q     <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
`ifdef CRC_EN
            crc_q      <= 8'h00;
`endif
        end else begin
            hr_q       <= hr_d;
            hr_full_q  <= hr_full_d;
            sr_q       <= sr_d;
            sr_full_q  <= sr_full_d;
            pre_cnt_q  <= pre_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            ready_q    <= ready_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
`ifdef CRC_EN
            crc_q      <= crc_d;
`endif
        end
    end

    assign o_byte_ready = ready_q;
    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_busy       = busy_q;
    assign o_underrun   = underrun_q;
endmodule
